// File: rtl/etc_record_framer_if.sv
// Framer-side bundle: measurement input (done/speed/valid_Epass), FIFO write port
// (write/data/full) and status (busy/dropped). Master is the framer, slave the environment.
interface etc_record_framer_if #(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8
);
    logic                   done;
    logic [WIDTH_SPEED-1:0] speed;
    logic [1:0]             valid_Epass;
    logic                   full;
    logic                   write;
    logic [DATA_SIZE-1:0]   data;
    logic                   busy;
    logic                   dropped;

    modport master (
        input  done, speed, valid_Epass, full,
        output write, data, busy, dropped
    );

    modport slave (
        output done, speed, valid_Epass, full,
        input  write, data, busy, dropped
    );
endinterface

// File: rtl/etc_record_framer.sv
// Turns one speed/E-pass measurement into an ASCII record "S dddd , c [CHK] CR LF" and
// streams it into the UART TX FIFO. Define ETC_FRAMER_CHECKSUM_EN to include the XOR byte.
module etc_record_framer #(
    parameter int WIDTH_SPEED = 14,
    parameter int DATA_SIZE   = 8,
    parameter int SAT_VALUE   = 9999
) (
    input logic                 clk,
    input logic                 reset,
    etc_record_framer_if.master bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONVERT = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam int CNT_W = $clog2(WIDTH_SPEED);
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(WIDTH_SPEED - 1);
    localparam logic [WIDTH_SPEED-1:0] SAT_W    = WIDTH_SPEED'(SAT_VALUE);
`ifdef ETC_FRAMER_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif

    logic [1:0]             state;
    logic [WIDTH_SPEED-1:0] bin;
    logic [15:0]            bcd;
    logic [15:0]            bcd_adj;
    logic [1:0]             epass;
    logic [CNT_W-1:0]       cnt;
    logic [3:0]             idx;
    logic [3:0]             nidx;
    logic [7:0]             data_r;
    logic [7:0]             next_byte;
    logic                   busy_r;
    logic                   dropped_r;
    logic [7:0]             d3, d2, d1, d0, cls;

    function automatic logic [WIDTH_SPEED-1:0] sat_speed(input logic [WIDTH_SPEED-1:0] s);
        return (s > SAT_W) ? SAT_W : s;
    endfunction

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the next shift.
    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int d = 0; d < 4; d++) begin
            if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adj(bcd);
    assign nidx    = idx + 4'd1;

    assign d3  = {4'h3, bcd[15:12]};
    assign d2  = {4'h3, bcd[11:8]};
    assign d1  = {4'h3, bcd[7:4]};
    assign d0  = {4'h3, bcd[3:0]};
    assign cls = {6'b001100, epass};

`ifdef ETC_FRAMER_CHECKSUM_EN
    logic [7:0] chk;
    assign chk = 8'h53 ^ d3 ^ d2 ^ d1 ^ d0 ^ 8'h2C ^ cls;
`endif

    // Byte to present after the current one is accepted; byte 0 ('S') is loaded on entry to SEND.
    always_comb begin
        next_byte = 8'h00;
        case (nidx)
            4'd1: next_byte = d3;
            4'd2: next_byte = d2;
            4'd3: next_byte = d1;
            4'd4: next_byte = d0;
            4'd5: next_byte = 8'h2C;
            4'd6: next_byte = cls;
`ifdef ETC_FRAMER_CHECKSUM_EN
            4'd7: next_byte = chk;
            4'd8: next_byte = 8'h0D;
            4'd9: next_byte = 8'h0A;
`else
            4'd7: next_byte = 8'h0D;
            4'd8: next_byte = 8'h0A;
`endif
            default: next_byte = 8'h00;
        endcase
    end

    assign bus.write   = (state == SEND) && !bus.full;
    assign bus.data    = data_r;
    assign bus.busy    = busy_r;
    assign bus.dropped = dropped_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            epass     <= '0;
            cnt       <= '0;
            idx       <= '0;
            data_r    <= 8'h00;
            busy_r    <= 1'b0;
            dropped_r <= 1'b0;
        end else begin
            if (bus.done && state != IDLE) dropped_r <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.done) begin
                        bin    <= sat_speed(bus.speed);
                        epass  <= bus.valid_Epass;
                        bcd    <= '0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd <= {bcd_adj[14:0], bin[WIDTH_SPEED-1]};
                    bin <= {bin[WIDTH_SPEED-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state  <= SEND;
                        idx    <= '0;
                        data_r <= 8'h53;
                    end
                end
                SEND: begin
                    if (!bus.full) begin
                        if (idx == LAST_IDX) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            idx    <= '0;
                        end else begin
                            idx    <= nidx;
                            data_r <= next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_etc_record_framer.sv
// Scoreboard bench for etc_record_framer: stimulus pushes the expected record bytes,
// a negedge monitor pops and compares each FIFO write.
module tb_etc_record_framer;
    localparam int SAT = 9999;
`ifdef ETC_FRAMER_CHECKSUM_EN
    localparam int FLEN = 10;
`else
    localparam int FLEN = 9;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    etc_record_framer_if #(.WIDTH_SPEED(14), .DATA_SIZE(8)) bus ();
    etc_record_framer dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    // Reference record built from decimal arithmetic on the saturated speed.
    function automatic void push_frame(int spd, int ep);
        int s;
        logic [7:0] b[$];
        logic [7:0] x;
        s = (spd > SAT) ? SAT : spd;
        b.push_back(8'h53);
        b.push_back(8'(48 + (s / 1000) % 10));
        b.push_back(8'(48 + (s / 100) % 10));
        b.push_back(8'(48 + (s / 10) % 10));
        b.push_back(8'(48 + s % 10));
        b.push_back(8'h2C);
        b.push_back(8'(48 + ep));
`ifdef ETC_FRAMER_CHECKSUM_EN
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
        b.push_back(x);
`endif
        b.push_back(8'h0D);
        b.push_back(8'h0A);
        foreach (b[i]) exp_q.push_back(b[i]);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.full) check("no_write_while_full", bus.write, 0);
            if (bus.write) begin
                if (exp_q.size() == 0) check("unexpected_write", bus.data, 32'hFFFF_FFFF);
                else check("frame_byte", bus.data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int spd, int ep, bit expect_frame);
        bus.speed       = 14'(spd);
        bus.valid_Epass = 2'(ep);
        bus.done        = 1'b1;
        if (expect_frame) push_frame(spd, ep);
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_idle(bit rand_full, string name);
        int c = 0;
        while ((exp_q.size() != 0 || bus.busy) && c < 400) begin
            if (rand_full) bus.full = ($urandom_range(0, 9) < 3);
            tick();
            c++;
        end
        bus.full = 1'b0;
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_busy_end"}, bus.busy, 0);
    endtask

    task automatic wait_remaining(int n, string name);
        int c = 0;
        while (exp_q.size() > n && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d bytes left, expected %0d", name, exp_q.size(), n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, nw, lastw, spd, r;
        bus.done = 1'b0;
        bus.speed = '0;
        bus.valid_Epass = '0;
        bus.full = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check("rst_write", bus.write, 0);
        check("rst_data", bus.data, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_dropped", bus.dropped, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Reference frame with latency and back-to-back timing
        bus.speed = 14'd123;
        bus.valid_Epass = 2'd2;
        bus.done = 1'b1;
        push_frame(123, 2);
        lat = -1; nw = 0; lastw = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.write) begin
                if (lat < 0) lat = c;
                nw++;
                lastw = c;
            end
            if (c == 1) check("busy_after_done", bus.busy, 1);
            @(posedge clk);
            #1;
            bus.done = 1'b0;
        end
        check("first_write_latency", lat, 15);
        check("write_count", nw, FLEN);
        check("last_write_cycle", lastw, 15 + FLEN - 1);
        check("busy_low_after_frame", bus.busy, 0);
        check("frame1_drained", exp_q.size(), 0);

        // Saturation and digit boundaries
        issue(16383, 0, 1); wait_idle(0, "sat_max");
        issue(10000, 1, 1); wait_idle(0, "sat_10000");
        issue(9999, 3, 1);  wait_idle(0, "exact_9999");
        issue(0, 0, 1);     wait_idle(0, "zero");

        // Back-pressure after byte 3
        issue(5, 1, 1);
        wait_remaining(FLEN - 4, "stall");
        tick();
        bus.full = 1'b1;
        repeat (3) tick();
        check("held_byte", bus.data, exp_q[0]);
        bus.full = 1'b0;
        wait_idle(0, "stall");

        // Overlapping done is dropped and sticky
        issue(4321, 1, 1);
        repeat (3) tick();
        issue(777, 2, 0);
        check("dropped_set", bus.dropped, 1);
        wait_idle(0, "overlap");
        check("dropped_sticky", bus.dropped, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("dropped_cleared", bus.dropped, 0);
        check("busy_after_reset", bus.busy, 0);

        // done in the cycle busy falls is a fresh frame
        issue(42, 1, 1);
        wait_remaining(0, "edge_first");
        tick();
        check("busy_fell", bus.busy, 0);
        issue(8765, 2, 1);
        check("busy_edge_accept", bus.busy, 1);
        wait_idle(0, "edge_second");
        check("edge_not_dropped", bus.dropped, 0);

        // Reset during byte 5
        issue(2468, 3, 1);
        wait_remaining(FLEN - 5, "midreset");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        check("midreset_write", bus.write, 0);
        check("midreset_busy", bus.busy, 0);
        issue(1357, 0, 1);
        wait_idle(0, "after_reset");

        // Randomized frames under random back-pressure
        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: spd = $urandom_range(0, 9999);
                1: spd = $urandom_range(10000, 16383);
                2: spd = ($urandom_range(0, 1) != 0) ? 9999 : 10000;
                default: spd = $urandom_range(0, 99);
            endcase
            issue(spd, $urandom_range(0, 3), 1);
            wait_idle(1, "rand");
        end
        check("final_dropped", bus.dropped, 0);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
